// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and defaults for the ALU sequencing controller
package alu_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SEL_W_DEF  = 3;

    // Opcode byte bit that requests chaining the result into the next operand A
    localparam int CHAIN_BIT = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - collects A, B, opcode bytes, drives external ALU, holds result (optional ALU_SEQ_CHAIN_EN)
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        op_count
);

    state_t state;

    // Registered "collecting bytes" flag; gated by ena so a frozen block never accepts
    logic ready_q;

`ifdef ALU_SEQ_CHAIN_EN
    // Chain request latched from the opcode byte, consumed when the result is accepted
    logic chain_q;
`else
    // Upper opcode bits carry no meaning in this build
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^in_data[DATA_W-1:SEL_W];
`endif

    assign in_ready = ready_q & ena;

    // Sequencer: gathers operands, captures the ALU result, waits for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            op_count  <= 8'd0;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q   <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a <= in_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (in_valid) begin
                        alu_b <= in_data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (in_valid) begin
                        alu_sel <= in_data[SEL_W-1:0];
`ifdef ALU_SEQ_CHAIN_EN
                        chain_q <= in_data[CHAIN_BIT];
`endif
                        ready_q <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for a full cycle; ALU output is settled
                    out_data  <= alu_result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        ready_q   <= 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
                        if (chain_q) begin
                            alu_a <= out_data;
                            state <= GET_B;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] op_count;

    alu_seq_ctrl #(.DATA_W(8), .SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        case (alu_sel)
            3'd0:    alu_result = alu_a & alu_b;
            3'd1:    alu_result = alu_a + alu_b;
            3'd2:    alu_result = alu_a - alu_b;
            3'd3:    alu_result = alu_a ^ alu_b;
            3'd4:    alu_result = alu_a | alu_b;
            default: alu_result = alu_a;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    int         total;
    int         bad;
    int         exp_count;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a handshake seen at this negedge completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && ena && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
            exp_count = (exp_count + 1) % 256;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("drain_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic do_op(input vec_t v);
        send_byte(v.a);
        send_byte(v.b);
        exp_q.push_back(v.exp);
        send_byte(v.op);
        wait_drain();
        check("op_count", op_count, exp_count);
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n     = 1'b1;
        exp_count = 0;
        tick();
    endtask

    initial begin
        vec_t hold_v;
        int   n;

        total     = 0;
        bad       = 0;
        exp_count = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        vecs[0] = '{a: 8'h12, b: 8'h34, op: 8'h01, exp: 8'h46};
        vecs[1] = '{a: 8'hF0, b: 8'h3C, op: 8'h00, exp: 8'h30};
        vecs[2] = '{a: 8'hFF, b: 8'h01, op: 8'h01, exp: 8'h00};
        vecs[3] = '{a: 8'h10, b: 8'h20, op: 8'h02, exp: 8'hF0};
        vecs[4] = '{a: 8'hA5, b: 8'h5A, op: 8'h03, exp: 8'hFF};
        vecs[5] = '{a: 8'h0F, b: 8'h30, op: 8'h04, exp: 8'h3F};
        vecs[6] = '{a: 8'h80, b: 8'h80, op: 8'h79, exp: 8'h00};
        vecs[7] = '{a: 8'h55, b: 8'h0F, op: 8'h7A, exp: 8'h46};

        // Reset values
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_sel", alu_sel, 3'd0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_op_count", op_count, 8'd0);
        check("rst_in_ready", in_ready, 1'b1);

        // Basic add with exact latency
        send_byte(8'h12);
        send_byte(8'h34);
        check("getop_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h01;
        exp_q.push_back(8'h46);
        tick();
        in_valid = 1'b0;
        check("lat_valid_c1", out_valid, 1'b0);
        check("exec_in_ready", in_ready, 1'b0);
        tick();
        check("lat_valid_c2", out_valid, 1'b1);
        check("lat_data_c2", out_data, 8'h46);
        tick();
        check("first_op_count", op_count, 8'd1);
        check("first_valid_drop", out_valid, 1'b0);
        check("first_in_ready", in_ready, 1'b1);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Consumer back-pressure: result held, stray input ignored
        out_ready = 1'b0;
        hold_v = '{a: 8'h20, b: 8'h01, op: 8'h01, exp: 8'h21};
        send_byte(hold_v.a);
        send_byte(hold_v.b);
        exp_q.push_back(hold_v.exp);
        send_byte(hold_v.op);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("hold_reach_done", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, 8'h21);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("hold_release_ready", in_ready, 1'b1);
        check("hold_release_valid", out_valid, 1'b0);
        check("hold_alu_a", alu_a, 8'h20);
        check("hold_alu_b", alu_b, 8'h01);
        check("hold_op_count", op_count, exp_count);

        // Enable low between B and opcode
        send_byte(8'h33);
        send_byte(8'h11);
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ena_in_ready", in_ready, 1'b0);
            check("ena_alu_a", alu_a, 8'h33);
            check("ena_alu_b", alu_b, 8'h11);
            check("ena_alu_sel", alu_sel, 3'd1);
        end
        in_valid = 1'b0;
        ena      = 1'b1;
        exp_q.push_back(8'h22);
        send_byte(8'h02);
        wait_drain();
        check("ena_op_count", op_count, exp_count);

        // Asynchronous reset while waiting for the opcode
        send_byte(8'hFF);
        send_byte(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_alu_a", alu_a, 8'h00);
        check("arst_alu_b", alu_b, 8'h00);
        check("arst_alu_sel", alu_sel, 3'd0);
        check("arst_out_data", out_data, 8'h00);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_op_count", op_count, 8'd0);
        exp_count = 0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_no_valid", out_valid, 1'b0);
        end
        check("arst_in_ready", in_ready, 1'b1);
        check("idle_out_ready_count", op_count, 8'd0);

        // Chain sequence
        exp_q.push_back(8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h81);
        wait_drain();
`ifdef ALU_SEQ_CHAIN_EN
        exp_q.push_back(8'h0A);
        send_byte(8'h02);
        send_byte(8'h01);
`else
        send_byte(8'h02);
        send_byte(8'h01);
        exp_q.push_back(8'h03);
        send_byte(8'h01);
`endif
        wait_drain();
        check("chain_op_count", op_count, exp_count);

        // Counter wrap after 256 completions
        do_reset();
        for (int i = 0; i < 256; i++) do_op(vecs[i % 8]);
        check("op_count_wrap", op_count, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width.
REQ-002 SHALL have parameter SEL_W, default 3, ALU operation-select width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  design enable; low freezes all state.
REQ-006 SHALL have port in_valid  input  1  in_data byte present this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  operand or opcode byte.
REQ-008 SHALL have port in_ready  output  1  controller accepts in_data this cycle.
REQ-009 SHALL have port alu_a  output  DATA_W  registered operand A to ALU.
REQ-010 SHALL have port alu_b  output  DATA_W  registered operand B to ALU.
REQ-011 SHALL have port alu_sel  output  SEL_W  registered operation select to ALU.
REQ-012 SHALL have port alu_result  input  DATA_W  combinational ALU result.
REQ-013 SHALL have port out_data  output  DATA_W  captured result.
REQ-014 SHALL have port out_valid  output  1  out_data valid, held until accepted.
REQ-015 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-016 SHALL have port op_count  output  8  completed-operation counter.

Function
REQ-017 SHALL implement FSM states IDLE, GET_B, GET_OP, EXEC, DONE.
REQ-018 IDLE: in_ready=1; in_valid -> alu_a<=in_data, go GET_B.
REQ-019 GET_B: in_ready=1; in_valid -> alu_b<=in_data, go GET_OP.
REQ-020 GET_OP: in_ready=1; in_valid -> alu_sel<=in_data[SEL_W-1:0], go EXEC; remaining bits ignored except per REQ-030.
REQ-021 EXEC: in_ready=0; out_data<=alu_result, out_valid<=1, go DONE; latency GET_OP accept to out_valid = 2 cycles.
REQ-022 DONE: in_ready=0; out_valid held with out_data stable until out_ready=1; on that edge out_valid<=0, op_count increments, go IDLE.
REQ-023 op_count SHALL wrap 255 -> 0.
REQ-024 in_valid while in_ready=0 SHALL be ignored, no data captured.
REQ-025 ena=0 SHALL hold state and all registers; in_ready SHALL read 0; out_valid SHALL hold its value.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, regardless of current state.
REQ-028 Reset values: alu_a=0, alu_b=0, alu_sel=0, out_data=0, out_valid=0, op_count=0; in_ready=1 after release.
REQ-029 Reset mid-operation SHALL discard partial operands; no result emitted.

Configuration
REQ-030 Macro ALU_SEQ_CHAIN_EN defined: opcode byte bit 7 = chain; on DONE acceptance with chain set, alu_a<=out_data and FSM goes GET_B instead of IDLE.
REQ-031 ALU_SEQ_CHAIN_EN undefined: bit 7 ignored; DONE always returns to IDLE.

Structure
REQ-032 Shared package alu_seq_pkg SHALL hold the state enum type and DATA_W/SEL_W defaults.
REQ-033 ALU itself SHALL remain external; no sub-module instantiated inside alu_seq_ctrl.

Verification
REQ-034 Reset then bytes 0x12, 0x34, 0x01 with out_ready=1, ALU model a+b -> out_data=0x46, out_valid exactly 2 cycles after opcode accept, op_count=1.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable; extra in_valid bytes ignored; out_ready=1 -> IDLE.
REQ-036 rst_n pulsed low in GET_OP after A=0xFF, B=0x01 -> all outputs reset values, out_valid never asserted.
REQ-037 ena=0 for 3 cycles between B and opcode -> state and operands frozen; operation completes correctly after ena=1.
REQ-038 256 completed operations -> op_count wraps to 0.
REQ-039 With ALU_SEQ_CHAIN_EN: 0x05, 0x03, 0x81 then 0x02, 0x01 (add model) -> results 0x08 then 0x0A; without macro, second sequence treats 0x02 as A.
